// File: rtl/cobs_uart_tx.sv
// -----------------------------------------------------------------------------
// cobs_uart_tx
//
// Host-bound transmit path. Accepts a byte stream framed by in_last, COBS-encodes
// it one group at a time, and serialises every encoded byte as 8N1 UART on txd.
// Each frame ends with a 0x00 delimiter byte.
//
// Non-zero payload bytes are collected into a group buffer of up to MAX_GROUP
// bytes. When a group closes (zero byte, full group, or end of frame) the code
// byte and the buffered data are sent back to back while input is stalled.
//
// Handshake: a byte transfers on a rising clk edge when in_valid && in_ready.
// in_ready depends only on internal state (never on in_valid). in_data and
// in_last are sampled only on a transfer.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-high
//   in_data       payload byte
//   in_valid      in_data valid
//   in_last       in_data is the final byte of the frame
//   in_ready      block accepts a byte this cycle
//   txd           UART serial output, idle high
//   busy          frame in progress (first accepted byte .. delimiter stop bit)
//   frame_done    one-cycle pulse during the last cycle of the delimiter stop bit
//   fsm_state     encoder state, for observation only
//   group_pending a group is open and still owes its code byte
// -----------------------------------------------------------------------------
module cobs_uart_tx #(
    parameter int CLKS_PER_BIT = 234,
    parameter int MAX_GROUP    = 254
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       txd,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] fsm_state,
    output logic       group_pending
);

    typedef enum logic [2:0] {
        COLLECT    = 3'd0,
        SEND_CODE  = 3'd1,
        SEND_DATA  = 3'd2,
        SEND_FINAL = 3'd3,
        SEND_DELIM = 3'd4
    } state_t;

    localparam int            CW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK    = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    FULL_MINUS1 = 8'(MAX_GROUP - 1);
    localparam logic [7:0]    FULL_CODE   = 8'(MAX_GROUP + 1);
    localparam logic [3:0]    STOP_BIT    = 4'd9;

    // -------------------------------------------------------------------------
    // Encoder state
    // -------------------------------------------------------------------------
    state_t     state,      state_n;
    logic [7:0] count,      count_n;
    logic [7:0] rd_idx,     rd_idx_n;
    logic       pending,    pending_n;
    logic       end_req,    end_req_n;
    logic       zero_close, zero_close_n;
    logic       busy_q,     busy_n;

    logic       wr_en;
    logic       post_data;
    logic       load;
    logic [7:0] load_byte;
    logic [7:0] rd_sel;
    logic [7:0] rd_byte;

    logic [7:0] group_mem [MAX_GROUP];

    // -------------------------------------------------------------------------
    // UART bit engine state
    // -------------------------------------------------------------------------
    logic          tx_active;
    logic [9:0]    tx_shift;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_clk;
    logic          byte_end;

    // Last cycle of the stop bit. The encoder loads the next byte in this very
    // cycle so consecutive bytes run with no idle time between them.
    assign byte_end = tx_active && (tx_clk == LAST_CLK) && (tx_bit == STOP_BIT);

    // While the code byte is on the wire the first data byte is prefetched;
    // while a data byte is on the wire the following one is prefetched.
    assign rd_sel  = (state == SEND_CODE) ? 8'd0 : (rd_idx + 8'd1);
    assign rd_byte = group_mem[rd_sel];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COLLECT;
            count      <= 8'd0;
            rd_idx     <= 8'd0;
            pending    <= 1'b1;
            end_req    <= 1'b0;
            zero_close <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            rd_idx     <= rd_idx_n;
            pending    <= pending_n;
            end_req    <= end_req_n;
            zero_close <= zero_close_n;
            busy_q     <= busy_n;
        end
    end

    // Group buffer: plain storage, contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            group_mem[count] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and byte-load logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        count_n      = count;
        rd_idx_n     = rd_idx;
        pending_n    = pending;
        end_req_n    = end_req;
        zero_close_n = zero_close;
        busy_n       = busy_q;
        wr_en        = 1'b0;
        post_data    = 1'b0;
        load         = 1'b0;
        load_byte    = 8'h00;

        case (state)
            COLLECT: begin
                // The UART is always idle in COLLECT, so a closing transfer
                // loads the code byte straight away.
                if (in_valid) begin
                    busy_n = 1'b1;
                    if (in_data != 8'h00) begin
                        wr_en   = 1'b1;
                        count_n = count + 8'd1;
                        if (count == FULL_MINUS1) begin
                            load      = 1'b1;
                            load_byte = FULL_CODE;
                            pending_n = 1'b0;
                            end_req_n = in_last;
                            state_n   = SEND_CODE;
                        end else if (in_last) begin
                            // code = new count + 1
                            load      = 1'b1;
                            load_byte = count + 8'd2;
                            end_req_n = 1'b1;
                            state_n   = SEND_CODE;
                        end
                    end else begin
                        // A zero closes the group and is implied by its code.
                        load      = 1'b1;
                        load_byte = count + 8'd1;
                        pending_n = 1'b1;
                        if (in_last) begin
                            end_req_n    = 1'b1;
                            zero_close_n = 1'b1;
                        end
                        state_n = SEND_CODE;
                    end
                end
            end

            SEND_CODE: begin
                if (byte_end) begin
                    if (count != 8'd0) begin
                        load      = 1'b1;
                        load_byte = rd_byte;
                        rd_idx_n  = 8'd0;
                        state_n   = SEND_DATA;
                    end else begin
                        post_data = 1'b1;
                    end
                end
            end

            SEND_DATA: begin
                if (byte_end) begin
                    if (rd_idx == (count - 8'd1)) begin
                        post_data = 1'b1;
                    end else begin
                        load      = 1'b1;
                        load_byte = rd_byte;
                        rd_idx_n  = rd_idx + 8'd1;
                    end
                end
            end

            SEND_FINAL: begin
                if (byte_end) begin
                    load      = 1'b1;
                    load_byte = 8'h00;
                    state_n   = SEND_DELIM;
                end
            end

            SEND_DELIM: begin
                if (byte_end) begin
                    busy_n       = 1'b0;
                    end_req_n    = 1'b0;
                    zero_close_n = 1'b0;
                    pending_n    = 1'b1;
                    state_n      = COLLECT;
                end
            end

            default: begin
                state_n = COLLECT;
            end
        endcase

        // Group fully sent: decide between the trailing 0x01 group (frame
        // ended on a zero), the delimiter, or collecting the next group.
        if (post_data) begin
            count_n = 8'd0;
            if (end_req && zero_close) begin
                load      = 1'b1;
                load_byte = 8'h01;
                state_n   = SEND_FINAL;
            end else if (end_req) begin
                load      = 1'b1;
                load_byte = 8'h00;
                state_n   = SEND_DELIM;
            end else begin
                state_n = COLLECT;
            end
        end
    end

    // -------------------------------------------------------------------------
    // UART bit engine: start bit, 8 data bits LSB first, stop bit. tx_shift[0]
    // is the bit currently on the line.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_bit    <= 4'd0;
            tx_clk    <= '0;
        end else if (load) begin
            tx_active <= 1'b1;
            tx_shift  <= {1'b1, load_byte, 1'b0};
            tx_bit    <= 4'd0;
            tx_clk    <= '0;
        end else if (tx_active) begin
            if (tx_clk == LAST_CLK) begin
                tx_clk <= '0;
                if (tx_bit == STOP_BIT) begin
                    tx_active <= 1'b0;
                end else begin
                    tx_bit   <= tx_bit + 4'd1;
                    tx_shift <= {1'b1, tx_shift[9:1]};
                end
            end else begin
                tx_clk <= tx_clk + CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign txd           = tx_active ? tx_shift[0] : 1'b1;
    assign in_ready      = (state == COLLECT);
    assign busy          = busy_q;
    assign frame_done    = (state == SEND_DELIM) && byte_end;
    assign fsm_state     = state;
    assign group_pending = pending;

endmodule

// File: tb/tb_cobs_uart_tx.sv
`timescale 1ns/1ps
module tb_cobs_uart_tx;

  localparam int CPB      = 4;
  localparam int BYTE_CYC = 10 * CPB;
  localparam int TIMEOUT  = 20000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       txd;
  logic       busy;
  logic       frame_done;
  logic [2:0] fsm_state;
  logic       group_pending;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cobs_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .txd(txd),
    .busy(busy),
    .frame_done(frame_done),
    .fsm_state(fsm_state),
    .group_pending(group_pending)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  // expected line bytes: {is_delimiter, must_follow_previous_with_no_gap, byte}
  logic [9:0] exp_q[$];
  logic [9:0] enc_q[$];
  logic [7:0] frame_q[$];
  logic [7:0] lit_q[$];

  logic mon_en = 1'b0;
  logic mon_active = 1'b0;
  int   gap = 1000;
  int   last_acc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: COBS encoding of frame_q into enc_q
  // ---------------------------------------------------------------------------
  task automatic encode();
    logic [7:0] grp[$];
    logic       last_zero;
    enc_q.delete();
    grp.delete();
    last_zero = 1'b0;
    foreach (frame_q[i]) begin
      if (frame_q[i] != 8'h00) begin
        grp.push_back(frame_q[i]);
        last_zero = 1'b0;
        if (grp.size() == 254) begin
          enc_q.push_back({2'b00, 8'hFF});
          foreach (grp[j]) enc_q.push_back({2'b01, grp[j]});
          grp.delete();
        end
      end else begin
        enc_q.push_back({2'b00, 8'(grp.size() + 1)});
        foreach (grp[j]) enc_q.push_back({2'b01, grp[j]});
        grp.delete();
        last_zero = 1'b1;
      end
    end
    if (last_zero) begin
      enc_q.push_back({2'b01, 8'h01});
    end else if (grp.size() > 0) begin
      enc_q.push_back({2'b00, 8'(grp.size() + 1)});
      foreach (grp[j]) enc_q.push_back({2'b01, grp[j]});
    end
    enc_q.push_back({2'b11, 8'h00});
  endtask

  // Pins the model against hand-computed encodings in lit_q.
  task automatic pin(input string name);
    check({name, "_len"}, enc_q.size(), lit_q.size());
    for (int i = 0; i < enc_q.size() && i < lit_q.size(); i++)
      check($sformatf("%s_b%0d", name, i), enc_q[i][7:0], lit_q[i]);
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_frame(input bit gaps);
    for (int i = 0; i < frame_q.size(); i++) begin
      int w;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
      in_data  = frame_q[i];
      in_last  = (i == frame_q.size() - 1);
      in_valid = 1'b1;
      w = 0;
      while (in_ready !== 1'b1 && w < TIMEOUT) begin
        @(negedge clk);
        w++;
      end
      if (w >= TIMEOUT) begin
        fail("accept_timeout");
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      last_acc = cyc;
      if (i == 0) check("busy_rise", busy, 1);
      if (gaps) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || mon_active) && w < 2 * TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    if (w >= 2 * TIMEOUT) fail("drain_timeout");
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);
    check("idle_txd", txd, 1);
  endtask

  task automatic run_frame(input bit gaps);
    encode();
    foreach (enc_q[i]) exp_q.push_back(enc_q[i]);
    drive_frame(gaps);
    drain();
  endtask

  task automatic gen_random(input int len, input int zero_pct);
    frame_q.delete();
    for (int i = 0; i < len; i++)
      frame_q.push_back(($urandom_range(0, 99) < zero_pct) ? 8'h00 : 8'($urandom_range(1, 255)));
  endtask

  // ---------------------------------------------------------------------------
  // Line monitor / compare process: checks every cycle of every byte
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [9:0] e;
    logic [9:0] bits;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (txd === 1'b0) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_byte");
            repeat (BYTE_CYC - 1) @(negedge clk);
            gap = 0;
          end else begin
            e = exp_q.pop_front();
            mon_active = 1'b1;
            if (e[8]) check($sformatf("byte_gap_%02h", e[7:0]), gap, 0);
            else      check("code_latency", ((cyc - last_acc) <= 2), 1);
            bits = {1'b1, e[7:0], 1'b0};
            for (int k = 0; k < BYTE_CYC; k++) begin
              if (k > 0) @(negedge clk);
              if (!mon_en) break;
              check($sformatf("txd_b%02h_k%0d", e[7:0], k), txd, bits[k / CPB]);
              check("in_ready_low", in_ready, 0);
              check("busy_high", busy, 1);
              check($sformatf("frame_done_k%0d", k), frame_done, (e[9] && k == BYTE_CYC - 1));
            end
            mon_active = 1'b0;
            gap = 0;
          end
        end else begin
          gap++;
          check("frame_done_idle", frame_done, 0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_txd", txd, 1);
    check("post_rst_in_ready", in_ready, 1);
    mon_en = 1'b1;

    frame_q = '{8'h55};
    lit_q   = '{8'h02, 8'h55, 8'h00};
    encode(); pin("pin_55");
    run_frame(1'b0);

    frame_q = '{8'h11, 8'h22, 8'h00, 8'h33};
    lit_q   = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    encode(); pin("pin_4b");
    run_frame(1'b0);

    frame_q = '{8'h00};
    lit_q   = '{8'h01, 8'h01, 8'h00};
    encode(); pin("pin_00");
    run_frame(1'b1);

    frame_q = '{8'h11, 8'h00};
    lit_q   = '{8'h02, 8'h11, 8'h01, 8'h00};
    encode(); pin("pin_1100");
    run_frame(1'b0);

    frame_q.delete(); lit_q.delete();
    lit_q.push_back(8'hFF);
    for (int i = 0; i < 254; i++) begin frame_q.push_back(8'h01); lit_q.push_back(8'h01); end
    lit_q.push_back(8'h00);
    encode(); pin("pin_254");
    run_frame(1'b0);

    frame_q.push_back(8'h01);
    lit_q.delete();
    lit_q.push_back(8'hFF);
    for (int i = 0; i < 254; i++) lit_q.push_back(8'h01);
    lit_q.push_back(8'h02); lit_q.push_back(8'h01); lit_q.push_back(8'h00);
    encode(); pin("pin_255");
    run_frame(1'b1);

    // Random frames, each driven once gap-free and once with random gaps.
    for (int n = 0; n < 6; n++) begin
      gen_random($urandom_range(1, 24), (n % 3 == 0) ? 40 : 15);
      run_frame(1'b0);
      run_frame(1'b1);
    end

    // Reset in the middle of a data bit of the second line byte.
    frame_q = '{8'h11, 8'h22, 8'h33};
    encode();
    foreach (enc_q[i]) exp_q.push_back(enc_q[i]);
    drive_frame(1'b0);
    repeat (BYTE_CYC + 3 * CPB + 2) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_txd", txd, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_frame_done", frame_done, 0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
    gap = 1000;
    @(negedge clk);
    mon_en = 1'b1;
    frame_q = '{8'h44};
    lit_q   = '{8'h02, 8'h44, 8'h00};
    encode(); pin("pin_44");
    run_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #900000;
    fail("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
